multiport_register_file: RTL

MULTIPORT_REGISTER_FILE -- requirements
Module: multiport_register_file

---
 rtl/multiport_register_file.sv | 103 ++++++++++
 1 files changed

// File: rtl/multiport_register_file.sv
// Two-write, N-read register file with write-through bypass
// and a per-register pending scoreboard.
module multiport_register_file #(
  parameter int DATA_WIDTH   = 32,
  parameter int REG_COUNT    = 32,
  parameter int READ_PORTS   = 2,
  parameter int ADDRESS_SIZE = $clog2(REG_COUNT),
  parameter int ZERO_REG     = 1
) (
  input  logic                               system_clock,
  input  logic                               system_reset_n,
  input  logic                               write_enable_a,
  input  logic                               write_enable_b,
  input  logic [ADDRESS_SIZE-1:0]            write_address_a,
  input  logic [ADDRESS_SIZE-1:0]            write_address_b,
  input  logic [DATA_WIDTH-1:0]              write_data_a,
  input  logic [DATA_WIDTH-1:0]              write_data_b,
  input  logic [READ_PORTS*ADDRESS_SIZE-1:0] read_address,
  output logic [READ_PORTS*DATA_WIDTH-1:0]   read_data,
  output logic [READ_PORTS-1:0]              read_pending,
  input  logic                               reserve_enable,
  input  logic [ADDRESS_SIZE-1:0]            reserve_address
);

  logic [DATA_WIDTH-1:0] r_regs [REG_COUNT];
  logic [REG_COUNT-1:0]  r_pend;

  logic w_wa_ok;
  logic w_wb_ok;
  logic w_rsv_ok;

  function automatic logic f_legal(
    input logic [ADDRESS_SIZE-1:0] a
  );
    return (32'(a) < REG_COUNT) &&
           !((ZERO_REG != 0) && (a == '0));
  endfunction

  assign w_wa_ok  = write_enable_a && f_legal(write_address_a);
  assign w_wb_ok  = write_enable_b && f_legal(write_address_b);
  assign w_rsv_ok = reserve_enable && f_legal(reserve_address);

  always_ff @(posedge system_clock or negedge system_reset_n) begin
    if (!system_reset_n) begin
      for (int k = 0; k < REG_COUNT; k++) begin
        r_regs[k] <= '0;
      end
      r_pend <= '0;
    end else begin
      for (int k = 0; k < REG_COUNT; k++) begin
        if (w_wb_ok && 32'(write_address_b) == k) begin
          r_regs[k] <= write_data_b;
        end else if (w_wa_ok && 32'(write_address_a) == k) begin
          r_regs[k] <= write_data_a;
        end
        // A new reservation outranks a completing write
        if (w_rsv_ok && 32'(reserve_address) == k) begin
          r_pend[k] <= 1'b1;
        end else if ((w_wa_ok && 32'(write_address_a) == k) ||
                     (w_wb_ok && 32'(write_address_b) == k)) begin
          r_pend[k] <= 1'b0;
        end
      end
    end
  end

  for (genvar gi = 0; gi < READ_PORTS; gi++) begin : g_rd
    logic [ADDRESS_SIZE-1:0] w_ra;
    logic [DATA_WIDTH-1:0]   w_rd;
    logic                    w_rp;
    logic                    w_hit_a;
    logic                    w_hit_b;

    assign w_ra    = read_address[gi*ADDRESS_SIZE +: ADDRESS_SIZE];
    assign w_hit_a = w_wa_ok && (write_address_a == w_ra);
    assign w_hit_b = w_wb_ok && (write_address_b == w_ra);

    always_comb begin
      w_rd = '0;
      w_rp = 1'b0;
      if (system_reset_n && f_legal(w_ra)) begin
        for (int k = 0; k < REG_COUNT; k++) begin
          if (32'(w_ra) == k) begin
            w_rd = r_regs[k];
            w_rp = r_pend[k];
          end
        end
        if (w_hit_b) begin
          w_rd = write_data_b;
        end else if (w_hit_a) begin
          w_rd = write_data_a;
        end
        if (w_hit_a || w_hit_b) begin
          w_rp = 1'b0;
        end
      end
    end

    assign read_data[gi*DATA_WIDTH +: DATA_WIDTH] = w_rd;
    assign read_pending[gi] = w_rp;
  end

endmodule
